msg_req_scheduler: RTL

Request scheduler in front of the 32-bit messenger microcontroller. Arbitrates the five message sources (network, error, interrupt, EU, breakpoint) into one granted request at a time. Freezes the granted source's parameters for the duration of service and returns a one-cycle acknowledge to that source when the microcontroller reports completion. A watchdog aborts a grant that is never completed.

---
 rtl/msg_req_scheduler.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/msg_req_scheduler.sv
// Request scheduler for the messenger microcontroller: arbitrates five message
// sources, freezes the winner's parameters and acknowledges on completion.
module msg_req_scheduler #(
    parameter int TIMEOUT = 4096
) (
    input  logic         CLK,
    input  logic         RESETn,
    input  logic         NETREQ,
    input  logic         ERRORREQ,
    input  logic         INTREQ,
    input  logic         EUREQ,
    input  logic         BKPT,
    input  logic [4:0]   MASK,
    input  logic [63:0]  EUPARAM,
    input  logic [15:0]  INTPARAM,
    input  logic [121:0] NETPARAM,
    input  logic         DONE,
    output logic         VALID,
    output logic [2:0]   SEL,
    output logic [4:0]   GNT,
    output logic [63:0]  PARAM,
    output logic [57:0]  PARAMHI,
    output logic [4:0]   PEND,
    output logic         EUACK,
    output logic         ERRACK,
    output logic         INTACK,
    output logic         NETACK,
    output logic         BKACK,
    output logic         TOUT
);

    localparam logic [2:0]  C_NET   = 3'd0;
    localparam logic [2:0]  C_ERR   = 3'd1;
    localparam logic [2:0]  C_INT   = 3'd2;
    localparam logic [2:0]  C_EU    = 3'd3;
    localparam logic [2:0]  C_BKPT  = 3'd4;
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, GRANT, ACK, HOLD} state_t;

    state_t        state_reg;
    logic          valid_reg;
    logic [2:0]    sel_reg;
    logic [4:0]    gnt_reg;
    logic [63:0]   param_reg;
    logic [57:0]   paramhi_reg;
    logic [4:0]    pend_reg;
    logic [4:0]    ack_reg;
    logic          tout_reg;
    logic [1:0]    rrp_reg;     // round-robin slot: 0=NET, 1=INT, 2=EU
    logic [15:0]   cnt_reg;

    logic [4:0]    req_vec;
    logic [4:0]    excl_vec;
    logic [4:0]    elig;
    logic [1:0]    slot_idx [3];
    logic [2:0]    slot_code [3];
    logic [2:0]    slot_hit;
    logic          win_any;
    logic          win_is_rr;
    logic [2:0]    win_code;
    logic [1:0]    rrp_next;
    logic [63:0]   param_next;
    logic [57:0]   paramhi_next;

    function automatic logic [2:0] rr_code(input logic [1:0] idx);
        case (idx)
            2'd0:    rr_code = C_NET;
            2'd1:    rr_code = C_INT;
            default: rr_code = C_EU;
        endcase
    endfunction

    function automatic logic [1:0] rr_step(input logic [1:0] idx, input logic [1:0] k);
        logic [2:0] s;
        s = {1'b0, idx} + {1'b0, k};
        rr_step = (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
    endfunction

    // Bit position in every 5-bit vector equals the source code.
    assign req_vec  = {BKPT, EUREQ, INTREQ, ERRORREQ, NETREQ};
    assign excl_vec = (state_reg == HOLD) ? (5'b00001 << sel_reg) : 5'b00000;
    assign elig     = MASK & req_vec & ~excl_vec;
    assign win_any  = |elig;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_rr_slot
            assign slot_idx[gi]  = rr_step(rrp_reg, 2'(gi));
            assign slot_code[gi] = rr_code(slot_idx[gi]);
            assign slot_hit[gi]  = elig[slot_code[gi]];
        end
    endgenerate

    always_comb begin
        win_code  = C_NET;
        win_is_rr = 1'b0;
        rrp_next  = rrp_reg;
        if (elig[C_ERR]) begin
            win_code = C_ERR;
        end else if (elig[C_BKPT]) begin
            win_code = C_BKPT;
        end else if (slot_hit[0]) begin
            win_code  = slot_code[0];
            win_is_rr = 1'b1;
            rrp_next  = rr_step(slot_idx[0], 2'd1);
        end else if (slot_hit[1]) begin
            win_code  = slot_code[1];
            win_is_rr = 1'b1;
            rrp_next  = rr_step(slot_idx[1], 2'd1);
        end else if (slot_hit[2]) begin
            win_code  = slot_code[2];
            win_is_rr = 1'b1;
            rrp_next  = rr_step(slot_idx[2], 2'd1);
        end
    end

    always_comb begin
        param_next   = 64'd0;
        paramhi_next = 58'd0;
        case (win_code)
            C_EU:  param_next = EUPARAM;
            C_INT: param_next = {48'd0, INTPARAM};
            C_NET: begin
                param_next   = NETPARAM[63:0];
                paramhi_next = NETPARAM[121:64];
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_reg   <= IDLE;
            valid_reg   <= 1'b0;
            sel_reg     <= 3'd0;
            gnt_reg     <= 5'd0;
            param_reg   <= 64'd0;
            paramhi_reg <= 58'd0;
            pend_reg    <= 5'd0;
            ack_reg     <= 5'd0;
            tout_reg    <= 1'b0;
            rrp_reg     <= 2'd0;
            cnt_reg     <= 16'd0;
        end else begin
            pend_reg <= MASK & req_vec;
            ack_reg  <= 5'd0;
            tout_reg <= 1'b0;
            case (state_reg)
                IDLE, HOLD: begin
                    if (win_any) begin
                        state_reg   <= GRANT;
                        valid_reg   <= 1'b1;
                        sel_reg     <= win_code;
                        gnt_reg     <= 5'b00001 << win_code;
                        param_reg   <= param_next;
                        paramhi_reg <= paramhi_next;
                        cnt_reg     <= 16'd0;
                        if (win_is_rr) begin
                            rrp_reg <= rrp_next;
                        end
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                GRANT: begin
                    // Completion takes precedence over a watchdog expiry in the same cycle.
                    if (DONE) begin
                        state_reg <= ACK;
                        valid_reg <= 1'b0;
                        gnt_reg   <= 5'd0;
                        ack_reg   <= gnt_reg;
                    end else if ((TIMEOUT != 0) && (cnt_reg == TO_LAST)) begin
                        state_reg <= IDLE;
                        valid_reg <= 1'b0;
                        gnt_reg   <= 5'd0;
                        tout_reg  <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + 16'd1;
                    end
                end
                ACK: begin
                    state_reg <= HOLD;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign VALID   = valid_reg;
    assign SEL     = sel_reg;
    assign GNT     = gnt_reg;
    assign PARAM   = param_reg;
    assign PARAMHI = paramhi_reg;
    assign PEND    = pend_reg;
    assign NETACK  = ack_reg[0];
    assign ERRACK  = ack_reg[1];
    assign INTACK  = ack_reg[2];
    assign EUACK   = ack_reg[3];
    assign BKACK   = ack_reg[4];
    assign TOUT    = tout_reg;

endmodule
